// File: rtl/snn_pkg.sv
// Shared definitions for the spiking/quantised layer engines: FSM state
// encoding, default widths, address-width helper and activation clamp.
package snn_pkg;

  localparam int DEF_NUM_IN    = 784;
  localparam int DEF_NUM_OUT   = 32;
  localparam int DEF_IN_W      = 8;
  localparam int DEF_W_W       = 8;
  localparam int DEF_ACC_W     = 28;
  localparam int DEF_ACC_SHIFT = 7;
  localparam int DEF_OUT_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_LAST,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Address width for a RAM of the given depth; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Saturate a signed value into the unsigned range [0, 2^out_w-1].
  // out_w is expected to be at most 31.
  function automatic logic [31:0] clamp_act(input logic signed [63:0] i_v,
                                            input int out_w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< out_w) - 64'sd1;
    if (i_v < 64'sd0) return 32'd0;
    if (i_v > hi)     return hi[31:0];
    return i_v[31:0];
  endfunction

endpackage

// File: rtl/snn_act_clamp.sv
// Activation stage: arithmetic right shift of the accumulator followed by a
// clamp into the unsigned output activation range. Purely combinational.
module snn_act_clamp
  import snn_pkg::*;
#(
  parameter int ACC_W     = DEF_ACC_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int ACC_SHIFT = DEF_ACC_SHIFT
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic        [OUT_W-1:0] o_act
);

  logic signed [ACC_W-1:0] w_shifted;
  logic signed [63:0]      w_wide;

  assign w_shifted = i_acc >>> ACC_SHIFT;
  assign w_wide    = 64'(w_shifted);
  assign o_act     = OUT_W'(clamp_act(w_wide, OUT_W));

endmodule

// File: rtl/snn_layer_mac.sv
// Layer sequencer / MAC engine. Streams x[i] and w[n][i] out of two
// registered-read RAMs, accumulates the products per neuron and writes one
// clamped activation per neuron to the output RAM. One layer per start pulse.
module snn_layer_mac
  import snn_pkg::*;
#(
  parameter int NUM_IN    = DEF_NUM_IN,
  parameter int NUM_OUT   = DEF_NUM_OUT,
  parameter int IN_W      = DEF_IN_W,
  parameter int W_W       = DEF_W_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int ACC_SHIFT = DEF_ACC_SHIFT,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int IN_AW     = addr_w(NUM_IN),
  parameter int W_AW      = addr_w(NUM_IN * NUM_OUT),
  parameter int OUT_AW    = addr_w(NUM_OUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IN_AW-1:0]  in_addr,
  input  logic [IN_W-1:0]   in_q,
  output logic [W_AW-1:0]   w_addr,
  input  logic [W_W-1:0]    w_q,
  output logic [OUT_AW-1:0] out_addr,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_we
);

  localparam int PROD_W = IN_W + W_W + 1;
  localparam logic [IN_AW-1:0]  I_LAST = IN_AW'(NUM_IN - 1);
  localparam logic [OUT_AW-1:0] N_LAST = OUT_AW'(NUM_OUT - 1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [IN_AW-1:0]        r_i;
  logic [W_AW-1:0]         r_widx;
  logic [OUT_AW-1:0]       r_n;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_valid;   // RAM data for an issued address arrives this cycle
  logic [OUT_W-1:0]        r_out_data;

  logic signed [PROD_W-1:0] w_x_ext;
  logic signed [PROD_W-1:0] w_w_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic [OUT_W-1:0]         w_act;
  logic                     w_last_issue;

  // Activation is unsigned, weight two's complement; both are widened to the
  // full product width so the multiply is exact in a signed context.
  assign w_x_ext      = {{(W_W + 1){1'b0}}, in_q};
  assign w_w_ext      = {{(IN_W + 1){w_q[W_W-1]}}, w_q};
  assign w_prod       = w_x_ext * w_w_ext;
  assign w_prod_ext   = ACC_W'(w_prod);
  assign w_acc_next   = r_acc + w_prod_ext;
  assign w_last_issue = (r_i == I_LAST);

  // The final product lands in LAST, so the clamp sees the completed sum and
  // the result is captured into r_out_data for the WRITE cycle.
  snn_act_clamp #(
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .ACC_SHIFT(ACC_SHIFT)
  ) u_act_clamp (
    .i_acc(w_acc_next),
    .o_act(w_act)
  );

  // Next-state decode for the layer sequencer.
  always_comb begin
    // NOTE: default first so every path assigns w_state_next; no latch.
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_RUN;
      ST_RUN:   if (w_last_issue) w_state_next = ST_LAST;
      ST_LAST:  w_state_next = ST_WRITE;
      ST_WRITE: w_state_next = (r_n == N_LAST) ? ST_DONE : ST_RUN;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // State register, address counters, accumulator and output data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments for all sequential state so every
      // register samples pre-edge values regardless of statement order.
      r_state    <= ST_IDLE;
      r_i        <= '0;
      r_widx     <= '0;
      r_n        <= '0;
      r_acc      <= '0;
      r_valid    <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_state <= w_state_next;
      r_valid <= (r_state == ST_RUN);
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_i    <= '0;
            r_widx <= '0;
            r_n    <= '0;
            r_acc  <= '0;
          end
        end
        ST_RUN: begin
          // Addresses hold on the last issue so they stay put through LAST/WRITE.
          if (!w_last_issue) begin
            r_i    <= r_i + IN_AW'(1);
            r_widx <= r_widx + W_AW'(1);
          end
          if (r_valid) r_acc <= w_acc_next;
        end
        ST_LAST: begin
          r_acc      <= w_acc_next;
          r_out_data <= w_act;
        end
        ST_WRITE: begin
          r_acc <= '0;
          if (r_n != N_LAST) begin
            r_n    <= r_n + OUT_AW'(1);
            r_i    <= '0;
            r_widx <= r_widx + W_AW'(1);
          end
        end
        ST_DONE: begin
          r_widx <= '0;
        end
        default: begin
          r_acc <= '0;
        end
      endcase
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign out_we   = (r_state == ST_WRITE);
  assign out_addr = r_n;
  assign out_data = r_out_data;
  assign in_addr  = r_i;
  assign w_addr   = r_widx;

endmodule

// File: tb/tb_snn_layer_mac.sv
// Testbench for snn_layer_mac: two instances (ACC_SHIFT 0 and 7) share
// stimulus and RAM contents; results are compared with a dot-product model.
module tb_snn_layer_mac;

  localparam int NUM_IN  = 4;
  localparam int NUM_OUT = 2;
  localparam int IN_AW   = 2;
  localparam int W_AW    = 3;
  localparam int OUT_AW  = 1;
  localparam int PER_N   = NUM_IN + 2;
  localparam int LAT     = 1 + NUM_OUT * PER_N;

  logic clk = 1'b0;
  logic rst;
  logic start;

  logic [IN_AW-1:0]  in_addr_a, in_addr_b;
  logic [W_AW-1:0]   w_addr_a, w_addr_b;
  logic [OUT_AW-1:0] out_addr_a, out_addr_b;
  logic [7:0]        out_data_a, out_data_b;
  logic              out_we_a, out_we_b, busy_a, busy_b, done_a, done_b;
  logic [7:0]        in_q_a, in_q_b, w_q_a, w_q_b;

  logic [7:0] x_mem [NUM_IN];
  logic [7:0] w_mem [NUM_IN*NUM_OUT];

  int n_checks = 0;
  int n_fail   = 0;
  int got_a [NUM_OUT];
  int got_b [NUM_OUT];

  always #10 clk = ~clk;

  snn_layer_mac #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .ACC_SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a),
    .in_addr(in_addr_a), .in_q(in_q_a), .w_addr(w_addr_a), .w_q(w_q_a),
    .out_addr(out_addr_a), .out_data(out_data_a), .out_we(out_we_a));

  snn_layer_mac #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .ACC_SHIFT(7)) dut_b (
    .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b),
    .in_addr(in_addr_b), .in_q(in_q_b), .w_addr(w_addr_b), .w_q(w_q_b),
    .out_addr(out_addr_b), .out_data(out_data_b), .out_we(out_we_b));

  // Registered-address RAMs, one read port set per instance.
  always @(posedge clk) begin
    in_q_a <= x_mem[in_addr_a];
    w_q_a  <= w_mem[w_addr_a];
    in_q_b <= x_mem[in_addr_b];
    w_q_b  <= w_mem[w_addr_b];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Dot product, arithmetic shift, saturate to 0..255.
  function automatic int model_out(input int n, input int shift);
    longint acc = 0;
    longint v;
    for (int i = 0; i < NUM_IN; i++)
      acc += longint'(x_mem[i]) * longint'($signed(w_mem[n*NUM_IN+i]));
    v = acc >>> shift;
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return int'(v);
  endfunction

  task automatic fill(input int xv, input int w0, input int w1);
    for (int i = 0; i < NUM_IN; i++) begin
      x_mem[i]          = 8'(xv);
      w_mem[i]          = 8'(w0);
      w_mem[NUM_IN + i] = 8'(w1);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NUM_IN; i++) x_mem[i] = 8'($urandom);
    for (int i = 0; i < NUM_IN*NUM_OUT; i++) w_mem[i] = 8'($urandom);
  endtask

  // Runs one layer from a start pulse and checks per-cycle timing, the
  // address trace, the write count and the written values of both instances.
  task automatic run_layer(input string name, input bit repulse);
    int done_k = -1, done_cnt = 0, we_a = 0, we_b = 0, tim_err = 0, addr_err = 0;
    for (int n = 0; n < NUM_OUT; n++) begin got_a[n] = -1; got_b[n] = -1; end
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= LAT + 5; k++) begin
      int  p, n;
      bit  in_layer, exp_busy, exp_done, exp_we;
      @(negedge clk);
      start    = repulse && (k == 5 || k == LAT);
      p        = (k - 1) % PER_N;
      n        = (k - 1) / PER_N;
      in_layer = (k <= NUM_OUT * PER_N);
      exp_busy = (k <= LAT);
      exp_done = (k == LAT);
      exp_we   = in_layer && (p == PER_N - 1);
      if (busy_a !== exp_busy || done_a !== exp_done || out_we_a !== exp_we ||
          busy_b !== exp_busy || done_b !== exp_done || out_we_b !== exp_we)
        tim_err++;
      if (in_layer && p < NUM_IN) begin
        if (int'(in_addr_a) != p || int'(w_addr_a) != n*NUM_IN + p ||
            int'(in_addr_b) != p || int'(w_addr_b) != n*NUM_IN + p)
          addr_err++;
      end
      if (done_a === 1'b1) begin done_cnt++; done_k = k; end
      if (out_we_a === 1'b1) begin we_a++; got_a[out_addr_a] = int'(out_data_a); end
      if (out_we_b === 1'b1) begin we_b++; got_b[out_addr_b] = int'(out_data_b); end
    end
    start = 1'b0;
    check({name, "/done_latency"}, done_k, LAT);
    check({name, "/done_count"}, done_cnt, 1);
    check({name, "/we_count_a"}, we_a, NUM_OUT);
    check({name, "/we_count_b"}, we_b, NUM_OUT);
    check({name, "/timing_errs"}, tim_err, 0);
    check({name, "/addr_errs"}, addr_err, 0);
    for (int n = 0; n < NUM_OUT; n++) begin
      check($sformatf("%s/out_a[%0d]", name, n), got_a[n], model_out(n, 0));
      check($sformatf("%s/out_b[%0d]", name, n), got_b[n], model_out(n, 7));
    end
  endtask

  // Reset asserted while neuron 1 is streaming: engine must drop to idle.
  task automatic reset_mid_layer();
    int we_seen = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= PER_N + 2; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid/busy_a", busy_a, 0);
    check("rst_mid/busy_b", busy_b, 0);
    check("rst_mid/out_we_a", out_we_a, 0);
    check("rst_mid/w_addr_a", w_addr_a, 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_we_a !== 1'b0 || out_we_b !== 1'b0 || busy_a !== 1'b0) we_seen++;
    end
    check("rst_mid/quiet_after", we_seen, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fill(0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset/busy", busy_a, 0);
    check("reset/done", done_a, 0);
    check("reset/out_we", out_we_a, 0);
    check("reset/in_addr", in_addr_a, 0);
    check("reset/w_addr", w_addr_a, 0);
    check("reset/out_addr", out_addr_a, 0);
    check("reset/out_data", out_data_b, 0);

    for (int i = 0; i < NUM_IN; i++) x_mem[i] = 8'(i + 1);
    for (int i = 0; i < NUM_IN*NUM_OUT; i++) w_mem[i] = 8'd1;
    run_layer("ramp_x_unit_w", 1'b0);

    fill(255, -128, -128);
    run_layer("neg_clamp", 1'b0);

    fill(255, 127, 127);
    run_layer("pos_clamp", 1'b0);

    fill(128, 64, 32);
    run_layer("shift_boundary", 1'b0);

    for (int r = 0; r < 4; r++) begin
      fill_random();
      run_layer($sformatf("random%0d", r), r[0]);
    end

    fill_random();
    reset_mid_layer();
    run_layer("after_reset", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
